// File: rtl/ow_pkg.sv
`default_nettype none
// ============================================================================
// ow_pkg : shared 1-Wire slave constants, state encoding and tick helpers
// Rev 1.0
// ============================================================================
package ow_pkg;

    localparam int unsigned STD_RESET_MIN_US     = 480;
    localparam int unsigned STD_PRESENCE_WAIT_US = 30;
    localparam int unsigned STD_PRESENCE_LEN_US  = 120;
    localparam int unsigned STD_SAMPLE_US        = 30;

    typedef logic [3:0] ow_state_t;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_LOW_MEAS   = 4'd1;
    localparam logic [3:0] ST_RST_HOLD   = 4'd2;
    localparam logic [3:0] ST_PRES_WAIT  = 4'd3;
    localparam logic [3:0] ST_PRES_DRIVE = 4'd4;
    localparam logic [3:0] ST_PRES_REL   = 4'd5;
    localparam logic [3:0] ST_SLOT_IDLE  = 4'd6;
    localparam logic [3:0] ST_SLOT_WAIT  = 4'd7;
    localparam logic [3:0] ST_SLOT_END   = 4'd8;

    function automatic int unsigned us_to_ticks(input int unsigned us,
                                                input int unsigned clk_per_us);
        return us * clk_per_us;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ow_sync2.sv
`default_nettype none
// ============================================================================
// ow_sync2 : two-flop bus synchroniser with falling-edge detect
// Rev 1.0
// ============================================================================
module ow_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic bus_i,
    output logic bus_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle-high reset value keeps a released line from looking like a fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= bus_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign bus_s_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/ow_slave_rx.sv
`default_nettype none
// ============================================================================
// ow_slave_rx : 1-Wire slave reset/presence handling and write-slot receiver
// Rev 1.0
// ============================================================================
module ow_slave_rx
    import ow_pkg::*;
#(
    parameter int unsigned CLK_PER_US       = 1,
    parameter int unsigned RESET_MIN_US     = STD_RESET_MIN_US,
    parameter int unsigned PRESENCE_WAIT_US = STD_PRESENCE_WAIT_US,
    parameter int unsigned PRESENCE_LEN_US  = STD_PRESENCE_LEN_US,
    parameter int unsigned SAMPLE_US        = STD_SAMPLE_US,
    parameter int unsigned FRAME_BITS       = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bus_in,
    output logic                          bus_pull_low,
    output logic                          o_presence_pulse,
    output logic                          o_bit_val,
    output logic                          o_bit_ready,
    output logic [FRAME_BITS-1:0]         o_frame,
    output logic                          o_frame_valid,
    output logic                          o_frame_err,
    output logic [$clog2(FRAME_BITS+1)-1:0] o_bit_count
);

    localparam int unsigned T_RESET  = us_to_ticks(RESET_MIN_US, CLK_PER_US);
    localparam int unsigned T_PWAIT  = us_to_ticks(PRESENCE_WAIT_US, CLK_PER_US);
    localparam int unsigned T_PLEN   = us_to_ticks(PRESENCE_LEN_US, CLK_PER_US);
    localparam int unsigned T_SAMPLE = us_to_ticks(SAMPLE_US, CLK_PER_US);
    localparam int unsigned TMR_W    = $clog2(max4(T_RESET, T_PWAIT, T_PLEN, T_SAMPLE) + 1);
    localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 1);

    // The fall cycle and the entry cycle are already low when the timer reads 0,
    // so a low of T_RESET cycles completes at timer value T_RESET-2.
    localparam logic [TMR_W-1:0] C_LOW_LAST   = TMR_W'(T_RESET - 2);
    localparam logic [TMR_W-1:0] C_PWAIT_LAST = TMR_W'(T_PWAIT - 1);
    localparam logic [TMR_W-1:0] C_PLEN_LAST  = TMR_W'(T_PLEN - 1);
    localparam logic [TMR_W-1:0] C_SAMPLE_AT  = TMR_W'(T_SAMPLE);
    localparam logic [CNT_W-1:0] C_FULL       = CNT_W'(FRAME_BITS);

    logic                  w_bus;
    logic                  w_fall;
    logic [FRAME_BITS-1:0] w_frame_shift;
    logic                  w_keep_timer;

    ow_state_t             state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  bit_val_q, bit_val_d;
    logic                  bit_ready_q, bit_ready_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [CNT_W-1:0]      count_q, count_d;

    ow_sync2 u_sync (
        .clk     (clk),
        .reset   (reset),
        .bus_i   (bus_in),
        .bus_s_o (w_bus),
        .fall_o  (w_fall)
    );

    generate
        if (FRAME_BITS == 1) begin : g_frame_one
            assign w_frame_shift = w_bus;
        end else begin : g_frame_multi
            assign w_frame_shift = {w_bus, frame_q[FRAME_BITS-1:1]};
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        bit_val_d     = bit_val_q;
        bit_ready_d   = 1'b0;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        count_d       = count_q;
        w_keep_timer  = 1'b0;

        if (count_q == C_FULL) begin
            frame_valid_d = 1'b1;
            count_d       = '0;
        end

        case (state_q)
            ST_IDLE:       if (w_fall) state_d = ST_LOW_MEAS;
            ST_LOW_MEAS: begin
                if (w_bus)                       state_d = ST_IDLE;
                else if (timer_q == C_LOW_LAST)  state_d = ST_RST_HOLD;
            end
            ST_RST_HOLD:   if (w_bus) state_d = ST_PRES_WAIT;
            ST_PRES_WAIT:  if (timer_q == C_PWAIT_LAST) state_d = ST_PRES_DRIVE;
            ST_PRES_DRIVE: if (timer_q == C_PLEN_LAST) state_d = ST_PRES_REL;
            ST_PRES_REL:   if (w_bus) state_d = ST_SLOT_IDLE;
            ST_SLOT_IDLE:  if (w_fall) state_d = ST_SLOT_WAIT;
            ST_SLOT_WAIT: begin
                if (timer_q == C_SAMPLE_AT) begin
                    bit_val_d    = w_bus;
                    bit_ready_d  = 1'b1;
                    frame_d      = w_frame_shift;
                    count_d      = count_q + 1'b1;
                    state_d      = ST_SLOT_END;
                    w_keep_timer = 1'b1;
                end
            end
            ST_SLOT_END: begin
                if (w_bus) begin
                    state_d = ST_SLOT_IDLE;
                end else if (timer_q == C_LOW_LAST) begin
                    state_d = ST_RST_HOLD;
                    if (count_q != '0 && count_q != C_FULL) begin
                        frame_err_d = 1'b1;
                        count_d     = '0;
                    end
                end
            end
            default:       state_d = ST_IDLE;
        endcase

        // Slot timing runs on from the slot's fall through SLOT_END.
        if (state_d != state_q && !w_keep_timer) begin
            timer_d = '0;
        end else if (timer_q != {TMR_W{1'b1}}) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            bit_val_q     <= 1'b0;
            bit_ready_q   <= 1'b0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_val_q     <= bit_val_d;
            bit_ready_q   <= bit_ready_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            count_q       <= count_d;
        end
    end

    assign bus_pull_low     = (state_q == ST_PRES_DRIVE);
    assign o_presence_pulse = (state_q == ST_PRES_DRIVE);
    assign o_bit_val        = bit_val_q;
    assign o_bit_ready      = bit_ready_q;
    assign o_frame          = frame_q;
    assign o_frame_valid    = frame_valid_q;
    assign o_frame_err      = frame_err_q;
    assign o_bit_count      = count_q;

endmodule
`default_nettype wire
